// File: rtl/error_link_pkg.sv
// error_link_pkg
// Definitions shared by both ends of the inter-node error link: the receiver
// state encoding, the serial framing constants and the frame-length helper.
// Frame on the wire: START_BIT, PDET_WIDTH data bits LSB first, one parity
// bit, STOP_BIT. The line idles at STOP_BIT.
package error_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } link_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Even parity: XOR over the data bits and the parity bit must equal this.
  localparam logic PARITY_EVEN = 1'b0;

  // Serial bits per frame: start + data + parity + stop.
  function automatic int frame_len(input int pdet_width);
    return pdet_width + 3;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// bit_sync
// Multi-flop synchronizer for a single asynchronous input, with a
// parameterized reset value so that idle-high lines come out of reset idle.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, loads RESET_VAL into every stage
//   d   - asynchronous input
//   q   - synchronized output, STAGES clocks behind d
module bit_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic q_reg;
      logic d_in;

      if (gi == 0) begin : g_first
        assign d_in = d;
      end else begin : g_next
        assign d_in = g_stage[gi-1].q_reg;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_reg <= RESET_VAL;
        end else begin
          q_reg <= d_in;
        end
      end
    end
  endgenerate

  assign q = g_stage[STAGES-1].q_reg;

endmodule

// File: rtl/error_link_rx.sv
// error_link_rx
// Receive end of the inter-node error link. Deserializes the neighbour's
// phase-detector error word and holds it for the error combiner. If no valid
// frame arrives for TIMEOUT_CYCLES the link is declared down and the held
// error is forced to zero so a dead neighbour does not steer the loop.
// Ports:
//   fpga_clk_i    - system clock, rising edge
//   reset_i       - asynchronous active-high reset
//   enable_i      - receiver enable; low drops any frame in progress
//   serial_i      - asynchronous serial line from the neighbour, idles high
//   error_o       - last valid error word (two's complement), 0 when link down
//   error_valid_o - one-cycle pulse when error_o takes a new received word
//   parity_err_o  - one-cycle pulse when a frame fails the parity check
//   frame_err_o   - one-cycle pulse when a frame has a low stop bit
//   link_up_o     - high from the first valid frame until timeout
module error_link_rx
  import error_link_pkg::*;
#(
  parameter int PDET_WIDTH     = 5,
  parameter int BIT_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  serial_i,
  output logic [PDET_WIDTH-1:0] error_o,
  output logic                  error_valid_o,
  output logic                  parity_err_o,
  output logic                  frame_err_o,
  output logic                  link_up_o
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int IDX_W = $clog2(PDET_WIDTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  // The start edge is seen on cycle E; loading half a bit minus one puts the
  // first sample at E+BIT_CYCLES/2, i.e. mid start bit. Later samples follow
  // every BIT_CYCLES.
  localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PDET_WIDTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_CYCLES);

  logic                  s;
  logic                  s_prev_reg;
  link_state_t           state_reg, state_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [IDX_W-1:0]      bit_idx_reg, bit_idx_next;
  logic [PDET_WIDTH-1:0] data_sr_reg, data_sr_next;
  logic [PDET_WIDTH:0]   sr_shift;
  logic                  parity_bit_reg, parity_bit_next;
  logic [TO_W-1:0]       timeout_cnt_reg;
  logic                  tick;
  logic                  stop_sample;
  logic                  parity_ok;
  logic                  valid_next, parity_err_next, frame_err_next;

  bit_sync #(
    .STAGES    (2),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (fpga_clk_i),
    .rst (reset_i),
    .d   (serial_i),
    .q   (s)
  );

  assign tick = (bit_cnt_reg == '0);

  // State register plus the frame datapath it sequences.
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg      <= IDLE;
      s_prev_reg     <= 1'b1;
      bit_cnt_reg    <= '0;
      bit_idx_reg    <= '0;
      data_sr_reg    <= '0;
      parity_bit_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      s_prev_reg     <= s;
      bit_cnt_reg    <= bit_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      data_sr_reg    <= data_sr_next;
      parity_bit_reg <= parity_bit_next;
    end
  end

  // Next state and datapath updates.
  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    bit_idx_next    = bit_idx_reg;
    data_sr_next    = data_sr_reg;
    parity_bit_next = parity_bit_reg;
    // New bits enter at the MSB so the first (LSB) bit ends up at bit 0.
    sr_shift        = {s, data_sr_reg};

    if (state_reg != IDLE && state_reg != WAIT_IDLE) begin
      bit_cnt_next = tick ? BIT_RELOAD : bit_cnt_reg - 1'b1;
    end

    case (state_reg)
      IDLE: begin
        // Edge, not level: a line still low after an abort never starts a frame.
        if (s_prev_reg == STOP_BIT && s == START_BIT) begin
          state_next   = START;
          bit_cnt_next = HALF_LOAD;
        end
      end
      START: begin
        if (tick) begin
          if (s != START_BIT) begin
            state_next = IDLE;  // glitch shorter than half a bit
          end else begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          data_sr_next = sr_shift[PDET_WIDTH:1];
          if (bit_idx_reg == LAST_IDX) begin
            state_next = PARITY;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          parity_bit_next = s;
          state_next      = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_next = (s == STOP_BIT) ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (s == STOP_BIT) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (!enable_i) begin
      state_next = IDLE;
    end
  end

  // Frame verdict at the stop sample. Stop-bit failure outranks parity, so at
  // most one of the three results is ever raised.
  always_comb begin
    stop_sample     = (state_reg == STOP) && tick && enable_i;
    parity_ok       = ((^data_sr_reg) ^ parity_bit_reg) == PARITY_EVEN;
    frame_err_next  = stop_sample && (s != STOP_BIT);
    parity_err_next = stop_sample && (s == STOP_BIT) && !parity_ok;
    valid_next      = stop_sample && (s == STOP_BIT) && parity_ok;
  end

  // Registered results, held error word and link supervision. A valid frame
  // takes priority over a timeout landing on the same cycle. The timeout
  // counter only runs while the link is up, so it rests at TIMEOUT_CYCLES
  // once the link has dropped.
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      error_o         <= '0;
      error_valid_o   <= 1'b0;
      parity_err_o    <= 1'b0;
      frame_err_o     <= 1'b0;
      link_up_o       <= 1'b0;
      timeout_cnt_reg <= '0;
    end else begin
      error_valid_o <= valid_next;
      parity_err_o  <= parity_err_next;
      frame_err_o   <= frame_err_next;
      if (valid_next) begin
        error_o         <= data_sr_reg;
        link_up_o       <= 1'b1;
        timeout_cnt_reg <= '0;
      end else if (link_up_o) begin
        if (timeout_cnt_reg >= TO_LAST) begin
          link_up_o       <= 1'b0;
          error_o         <= '0;
          timeout_cnt_reg <= TO_MAX;
        end else begin
          timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_error_link_rx.sv
// tb_error_link_rx
// Drives whole serial frames onto serial_i and checks every result pulse
// against an expectation queued when the frame's start bit was driven.
// Expected pulse cycle = start-bit drive cycle + 2 (synchronizer) + 61.
module tb_error_link_rx;
  import error_link_pkg::*;

  localparam int W         = 5;
  localparam int BC        = 8;
  localparam int TO        = 1024;
  localparam int FL        = frame_len(W);
  localparam int PULSE_OFS = 2 + 61;
  localparam int KV        = 0;  // valid word
  localparam int KP        = 1;  // parity error
  localparam int KF        = 2;  // frame error

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         ser;
  logic [W-1:0] err;
  logic         vld;
  logic         perr;
  logic         ferr;
  logic         lnk;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int v_cyc;

  typedef struct {
    int           kind;
    int           cyc;
    logic [W-1:0] err;
    logic         link;
  } exp_t;

  typedef struct {
    logic [W-1:0] data;
    logic         par;
    logic         stp;
    int           idle;
    int           kind;
    logic [W-1:0] err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  error_link_rx #(
    .PDET_WIDTH     (W),
    .BIT_CYCLES     (BC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .fpga_clk_i    (clk),
    .reset_i       (rst),
    .enable_i      (en),
    .serial_i      (ser),
    .error_o       (err),
    .error_valid_o (vld),
    .parity_err_o  (perr),
    .frame_err_o   (ferr),
    .link_up_o     (lnk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called once per cycle at the falling edge.
  task automatic monitor();
    int   np;
    int   kind;
    exp_t e;
    np = int'(vld) + int'(perr) + int'(ferr);
    if (np > 1) check("single_pulse", np, 1);
    if (np > 0) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", np, 0);
      end else begin
        e    = sb.pop_front();
        kind = ferr ? KF : (perr ? KP : KV);
        $display("cycle %0d: pulse kind=%0d error_o=%b link_up_o=%b (expected kind=%0d cycle=%0d error_o=%b)",
                 cyc, kind, err, lnk, e.kind, e.cyc, e.err);
        check("pulse_kind", kind, e.kind);
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_error_o", int'(err), int'(e.err));
        check("pulse_link_up", int'(lnk), int'(e.link));
      end
    end
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      check("missing_pulse_cycle", cyc, e.cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input int n);
    ser = b;
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic par, input logic stp,
                            input int kind, input logic [W-1:0] exp_err, input logic exp_link);
    logic [FL-1:0] bits;
    bits = {stp, par, d, START_BIT};
    sb.push_back('{kind, cyc + PULSE_OFS, exp_err, exp_link});
    for (int i = 0; i < FL; i++) drive(bits[i], BC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    ser = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_error_o", int'(err), 0);
    check("reset_error_valid_o", int'(vld), 0);
    check("reset_parity_err_o", int'(perr), 0);
    check("reset_frame_err_o", int'(ferr), 0);
    check("reset_link_up_o", int'(lnk), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 4);

    // data, parity, stop, idle bits after, expected kind, expected error_o
    vecs[0] = '{5'b10011, 1'b1, 1'b1, 4, KV, 5'b10011};
    vecs[1] = '{5'b00101, 1'b1, 1'b1, 4, KP, 5'b10011};
    vecs[2] = '{5'b11000, 1'b0, 1'b1, 0, KV, 5'b11000};
    vecs[3] = '{5'b01110, 1'b0, 1'b0, 4, KF, 5'b11000};  // bad stop outranks bad parity
    vecs[4] = '{5'b00000, 1'b0, 1'b1, 4, KV, 5'b00000};
    vecs[5] = '{5'b01101, 1'b1, 1'b1, 4, KV, 5'b01101};
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stp, vecs[i].kind, vecs[i].err, 1'b1);
      drive(1'b1, vecs[i].idle);
    end

    // Bad stop bit, line stuck low for 40 cycles, then a good frame.
    send_frame(5'b00110, 1'b0, 1'b0, KF, 5'b01101, 1'b1);
    drive(1'b0, 40);
    drive(1'b1, 8);
    send_frame(5'b01111, 1'b0, 1'b1, KV, 5'b01111, 1'b1);
    drive(1'b1, 4);

    // Two-cycle glitch on the idle line.
    drive(1'b0, 2);
    drive(1'b1, 80);
    @(negedge clk);
    check("glitch_error_o", int'(err), 5'b01111);
    check("glitch_link_up", int'(lnk), 1);
    check("glitch_no_pending", sb.size(), 0);
    monitor();
    @(posedge clk);
    #1;

    // Timeout: link drops exactly TO cycles after the valid pulse.
    v_cyc = cyc + PULSE_OFS;
    send_frame(5'b00011, 1'b0, 1'b1, KV, 5'b00011, 1'b1);
    while (cyc < v_cyc + TO - 1) step();
    @(negedge clk);
    check("pre_timeout_link_up", int'(lnk), 1);
    check("pre_timeout_error_o", int'(err), 5'b00011);
    monitor();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("timeout_link_up", int'(lnk), 0);
    check("timeout_error_o", int'(err), 0);
    monitor();
    @(posedge clk);
    #1;
    send_frame(5'b00110, 1'b0, 1'b1, KV, 5'b00110, 1'b1);
    drive(1'b1, 4);

    // Back-to-back frames, then a third frame aborted mid-data (01010).
    send_frame(5'b00001, 1'b1, 1'b1, KV, 5'b00001, 1'b1);
    send_frame(5'b11111, 1'b1, 1'b1, KV, 5'b11111, 1'b1);
    drive(1'b0, BC);      // start
    drive(1'b0, BC);      // d0
    drive(1'b1, BC);      // d1
    drive(1'b0, 4);       // first half of d2
    en = 1'b0;
    drive(1'b0, 4);
    drive(1'b1, BC);      // d3
    drive(1'b0, BC);      // d4
    drive(1'b0, BC);      // parity
    drive(1'b1, BC);      // stop
    drive(1'b1, 20);
    en = 1'b1;
    drive(1'b1, 4);
    @(negedge clk);
    check("abort_error_o", int'(err), 5'b11111);
    check("abort_link_up", int'(lnk), 1);
    monitor();
    @(posedge clk);
    #1;

    // Receiver still works after the abort.
    send_frame(5'b10000, 1'b1, 1'b1, KV, 5'b10000, 1'b1);
    drive(1'b1, 8);
    check("final_no_pending", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/error_link_rx.md
Name: error_link_rx

Overview:
Receive end of the inter-node error link. Each network node serializes its phase-detector error (left/above outputs) onto one wire toward its neighbour. This block deserializes that wire inside the neighbour and presents a held, signed error word to the error combiner (right/bottom error inputs). Clocked by the FPGA system clock. It zeroes the error when the neighbour goes silent, so a dead link contributes nothing to the loop.

Parameters:
PDET_WIDTH, 5, width of the signed error word carried per frame
BIT_CYCLES, 8, fpga_clk cycles per serial bit; even, >= 4
TIMEOUT_CYCLES, 1024, fpga_clk cycles without a valid frame before the link is declared down

Ports:
fpga_clk_i  input  1  system clock; all logic on rising edge
reset_i  input  1  asynchronous, active-high reset
enable_i  input  1  receiver enable; low aborts any frame in progress
serial_i  input  1  asynchronous serial line from neighbour; idles high
error_o  output  PDET_WIDTH  last valid received error, signed two's complement; 0 when link down
error_valid_o  output  1  one-cycle pulse when error_o is updated
parity_err_o  output  1  one-cycle pulse when a frame is rejected for bad parity
frame_err_o  output  1  one-cycle pulse when a frame is rejected for stop bit = 0
link_up_o  output  1  high from first valid frame until timeout

Behaviour:
- Clocking and reset: single clock fpga_clk_i; reset_i is asynchronous and active-high.
- Reset values: error_o=0, error_valid_o=0, parity_err_o=0, frame_err_o=0, link_up_o=0. State is IDLE, synchronizer flops are 1, timeout counter is 0.
- Frame format: start bit (0), PDET_WIDTH data bits LSB first, even parity bit (XOR of data bits and parity = 0), stop bit (1). Line idles 1.
- Synchronizer: serial_i passes through a 2-FF synchronizer with reset value 1. All decisions use the synchronized signal s.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE -> START when s falls from 1 to 0 (call this cycle E). The bit-period counter is loaded so that samples land at mid-bit.
- Sample times: start at E+BIT_CYCLES/2; data bit k at E+BIT_CYCLES/2+(k+1)*BIT_CYCLES; parity at +(PDET_WIDTH+1)*BIT_CYCLES; stop at +(PDET_WIDTH+2)*BIT_CYCLES.
- START: if the mid-start sample is 1, treat it as a glitch. Return to IDLE with no flags.
- DATA: shift the samples into a PDET_WIDTH shift register. Go to PARITY after bit PDET_WIDTH-1.
- PARITY: latch the parity sample, then go to STOP.
- STOP, in priority order, with the result registered one cycle after the stop sample:
  - stop=0: frame_err_o pulses, error_o holds, go to WAIT_IDLE.
  - else parity bad: parity_err_o pulses, error_o holds, go to IDLE.
  - else: error_o <= shift register, error_valid_o pulses, link_up_o <= 1, timeout counter cleared, go to IDLE.
- Only one of the three pulses may ever fire in a given cycle.
- WAIT_IDLE: remain until s=1, then go to IDLE. A low line never retriggers a start.
- Latency: with defaults, error_valid_o is high at cycle E+61.
- Back-to-back frames: a new start edge is accepted on the first cycle after returning to IDLE (zero idle bits allowed after stop).
- Timeout: the counter increments every cycle while link_up_o=1 and saturates at TIMEOUT_CYCLES. On reaching TIMEOUT_CYCLES: link_up_o <= 0, error_o <= 0, no pulse.
  - A valid frame completing in the same cycle as the timeout wins: link stays up and error_o is updated.
- enable_i low: synchronously force IDLE and discard the partial frame, with no flags. error_o and link_up_o hold; the timeout counter keeps running.
- Reset mid-frame: everything returns to reset values immediately.
- Arithmetic: error_o is an unsigned bit copy of the received word, interpreted as signed downstream. No sign extension or saturation is done here.

Decomposition:
- Shared package error_link_pkg, common with the future transmitter:
  - state enum
  - START_BIT=0, STOP_BIT=1
  - parity sense (even)
  - frame length function PDET_WIDTH+3
- Natural sub-module: bit_sync, a 2-FF synchronizer with parameterized reset value (1 here). It is reused for reference-clock inputs elsewhere.

Test Plan:
- Reset, then one frame carrying 5'b10011 (-13), parity 1, stop 1 -> error_valid_o pulses once at E+61; error_o=5'b10011; link_up_o=1; no error pulses.
- Frame 5'b00101 with parity bit 1 (wrong) -> parity_err_o pulses at E+61; error_o keeps previous value; link_up_o unchanged.
- Frame with stop=0, line then held low 40 cycles before returning high -> frame_err_o pulses once; no new start is detected until the line is high; the next good frame 5'b01111 is received correctly.
- 2-cycle low glitch on an idle line -> no pulses, state back to IDLE, error_o unchanged.
- Valid frame 5'b00011, then line idle 1024 cycles -> link_up_o drops and error_o=0 exactly TIMEOUT_CYCLES after the valid pulse; the next valid frame restores link_up_o=1.
- Two back-to-back frames with no idle bits (5'b00001 then 5'b11111), then a third frame aborted by enable_i low mid-data -> two valid pulses with correct words, abort produces no flags, error_o=5'b11111.
